// File: rtl/float_unpacker_if.sv
// Operand-path bus for the float unpacker: input handshake, raw binary32
// operand, and the decoded fields/class flags with their output handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid high must
// keep its data stable until that transfer; ready may depend combinationally
// on the consumer's own downstream ready.
interface float_unpacker_if #(
  parameter int EXP_W = 10
);

  // Upstream side: operand in
  logic             valid_in;
  logic             ready_out;
  logic [31:0]      float_in;

  // Downstream side: decoded operand out
  logic             valid_out;
  logic             ready_in;
  logic             sgn;
  logic [EXP_W-1:0] exp;
  logic [23:0]      man;
  logic             zero;
  logic             inf;
  logic             sNaN;
  logic             qNaN;
  logic             denormal;

  // The unpacker itself
  modport slave (
    input  valid_in,
    input  float_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output sgn,
    output exp,
    output man,
    output zero,
    output inf,
    output sNaN,
    output qNaN,
    output denormal
  );

  // Whatever feeds operands in and consumes decoded results
  modport master (
    output valid_in,
    output float_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  sgn,
    input  exp,
    input  man,
    input  zero,
    input  inf,
    input  sNaN,
    input  qNaN,
    input  denormal
  );

endinterface

// File: rtl/float_unpacker.sv
// Float unpacker: decodes a raw binary32 word into sign, unbiased signed
// exponent, 24-bit significand with explicit hidden bit, and class flags.
// Subnormals are normalised one left shift per cycle so every finite
// nonzero result leaves with man[23] set.
module float_unpacker #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  float_unpacker_if.slave  bus,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fixed exponent values used by the decoder, in EXP_W-bit two's complement
  localparam logic [EXP_W-1:0] EXP_BIAS    = EXP_W'(127);
  localparam logic [EXP_W-1:0] EXP_SPECIAL = EXP_W'(128);
  localparam logic [EXP_W-1:0] EXP_SUBN    = EXP_W'(-126);
  localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);

  // Registered state and data outputs
  state_t           r_state;
  logic             r_sgn;
  logic [EXP_W-1:0] r_exp;
  logic [23:0]      r_man;
  logic             r_zero;
  logic             r_inf;
  logic             r_snan;
  logic             r_qnan;
  logic             r_denormal;

  // Next values
  state_t           w_state_nxt;
  logic             w_sgn_nxt;
  logic [EXP_W-1:0] w_exp_nxt;
  logic [23:0]      w_man_nxt;
  logic             w_zero_nxt;
  logic             w_inf_nxt;
  logic             w_snan_nxt;
  logic             w_qnan_nxt;
  logic             w_denormal_nxt;

  // Decoder results for the operand currently on float_in
  state_t           w_dec_state;
  logic [EXP_W-1:0] w_dec_exp;
  logic [23:0]      w_dec_man;
  logic             w_dec_zero;
  logic             w_dec_inf;
  logic             w_dec_snan;
  logic             w_dec_qnan;
  logic             w_dec_denormal;

  // Field split and handshake
  logic [7:0]       w_e;
  logic [22:0]      w_f;
  logic             w_ready_out;
  logic             w_valid_out;
  logic             w_accept;

  assign w_e      = bus.float_in[30:23];
  assign w_f      = bus.float_in[22:0];
  assign w_accept = bus.valid_in && w_ready_out;

  // Classify the incoming word and build its exponent/significand; the
  // target state says whether it still needs normalising.
  always_comb begin
    w_dec_state    = DONE;
    w_dec_exp      = '0;
    w_dec_man      = '0;
    w_dec_zero     = 1'b0;
    w_dec_inf      = 1'b0;
    w_dec_snan     = 1'b0;
    w_dec_qnan     = 1'b0;
    w_dec_denormal = 1'b0;
    if (w_e == 8'd0) begin
      if (w_f == 23'd0) begin
        w_dec_zero = 1'b1;
      end else begin
        // Subnormal: real exponent is -126 with no hidden bit; shifted later
        w_dec_denormal = 1'b1;
        w_dec_exp      = EXP_SUBN;
        w_dec_man      = {1'b0, w_f};
        w_dec_state    = NORM;
      end
    end else if (w_e == 8'hFF) begin
      w_dec_exp = EXP_SPECIAL;
      w_dec_man = {1'b0, w_f};
      if (w_f == 23'd0) begin
        w_dec_inf = 1'b1;
      end else begin
        // frac[22] distinguishes quiet from signalling NaN
        w_dec_qnan = w_f[22];
        w_dec_snan = !w_f[22];
      end
    end else begin
      w_dec_exp = {{(EXP_W-8){1'b0}}, w_e} - EXP_BIAS;
      w_dec_man = {1'b1, w_f};
    end
  end

  // Next-state and next-data selection for IDLE / NORM / DONE
  always_comb begin
    w_state_nxt    = r_state;
    w_sgn_nxt      = r_sgn;
    w_exp_nxt      = r_exp;
    w_man_nxt      = r_man;
    w_zero_nxt     = r_zero;
    w_inf_nxt      = r_inf;
    w_snan_nxt     = r_snan;
    w_qnan_nxt     = r_qnan;
    w_denormal_nxt = r_denormal;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt    = w_dec_state;
          w_sgn_nxt      = bus.float_in[31];
          w_exp_nxt      = w_dec_exp;
          w_man_nxt      = w_dec_man;
          w_zero_nxt     = w_dec_zero;
          w_inf_nxt      = w_dec_inf;
          w_snan_nxt     = w_dec_snan;
          w_qnan_nxt     = w_dec_qnan;
          w_denormal_nxt = w_dec_denormal;
        end
      end
      NORM: begin
        // Shift until the leading one lands in the hidden-bit position
        w_man_nxt = r_man << 1;
        w_exp_nxt = r_exp - EXP_ONE;
        if (r_man[22]) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.ready_in) begin
          if (w_accept) begin
            // Result consumed and replaced in the same cycle: no bubble
            w_state_nxt    = w_dec_state;
            w_sgn_nxt      = bus.float_in[31];
            w_exp_nxt      = w_dec_exp;
            w_man_nxt      = w_dec_man;
            w_zero_nxt     = w_dec_zero;
            w_inf_nxt      = w_dec_inf;
            w_snan_nxt     = w_dec_snan;
            w_qnan_nxt     = w_dec_qnan;
            w_denormal_nxt = w_dec_denormal;
          end else begin
            w_state_nxt    = IDLE;
            w_sgn_nxt      = 1'b0;
            w_exp_nxt      = '0;
            w_man_nxt      = '0;
            w_zero_nxt     = 1'b0;
            w_inf_nxt      = 1'b0;
            w_snan_nxt     = 1'b0;
            w_qnan_nxt     = 1'b0;
            w_denormal_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs derived from the current state
  always_comb begin
    w_valid_out = (r_state == DONE);
    w_ready_out = (r_state == IDLE) || ((r_state == DONE) && bus.ready_in);
  end

  // State and data registers; reset and flush clear everything and win
  // over any accept or normalisation step in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state    <= IDLE;
      r_sgn      <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
      r_zero     <= 1'b0;
      r_inf      <= 1'b0;
      r_snan     <= 1'b0;
      r_qnan     <= 1'b0;
      r_denormal <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sgn      <= w_sgn_nxt;
      r_exp      <= w_exp_nxt;
      r_man      <= w_man_nxt;
      r_zero     <= w_zero_nxt;
      r_inf      <= w_inf_nxt;
      r_snan     <= w_snan_nxt;
      r_qnan     <= w_qnan_nxt;
      r_denormal <= w_denormal_nxt;
    end
  end

  assign bus.ready_out = w_ready_out;
  assign bus.valid_out = w_valid_out;
  assign bus.sgn       = r_sgn;
  assign bus.exp       = r_exp;
  assign bus.man       = r_man;
  assign bus.zero      = r_zero;
  assign bus.inf       = r_inf;
  assign bus.sNaN      = r_snan;
  assign bus.qNaN      = r_qnan;
  assign bus.denormal  = r_denormal;
  assign o_state       = r_state;

endmodule
